// File: rtl/red_pitaya_dec_pkg.sv
// Shared definitions for the ADC decimator: sample/counter widths,
// decimation codes and the code -> window length / shift mapping.
package red_pitaya_dec_pkg;

    localparam int DEC_DW    = 14;
    localparam int DEC_CNT_W = 17;

    localparam logic [2:0] DEC_CODE_1     = 3'd0;
    localparam logic [2:0] DEC_CODE_8     = 3'd1;
    localparam logic [2:0] DEC_CODE_64    = 3'd2;
    localparam logic [2:0] DEC_CODE_1024  = 3'd3;
    localparam logic [2:0] DEC_CODE_8192  = 3'd4;
    localparam logic [2:0] DEC_CODE_65536 = 3'd5;

    // log2 of the window length; unused codes fall back to N=1
    function automatic logic [4:0] dec_shift(input logic [2:0] code);
        case (code)
            DEC_CODE_8:     return 5'd3;
            DEC_CODE_64:    return 5'd6;
            DEC_CODE_1024:  return 5'd10;
            DEC_CODE_8192:  return 5'd13;
            DEC_CODE_65536: return 5'd16;
            default:        return 5'd0;
        endcase
    endfunction

    // window length N (65536 still fits the 17-bit counter width)
    function automatic logic [DEC_CNT_W-1:0] dec_len(input logic [2:0] code);
        logic [DEC_CNT_W-1:0] one;
        one = 1;
        return one << dec_shift(code);
    endfunction

    // terminal count N-1, built as a low-bit mask so no subtractor is needed
    function automatic logic [DEC_CNT_W-1:0] dec_last(input logic [2:0] code);
        return ~({DEC_CNT_W{1'b1}} << dec_shift(code));
    endfunction

endpackage

// File: rtl/red_pitaya_adc_decimator.sv
// Decimates the equalized 14-bit ADC stream by N, emitting either the
// floor-mean or the last sample of each N-sample window with a 1-cycle strobe.
module red_pitaya_adc_decimator
    import red_pitaya_dec_pkg::*;
#(
    parameter int DW    = DEC_DW,
    parameter int CNT_W = DEC_CNT_W
) (
    input  logic             adc_clk_i,
    input  logic             adc_rst_i,
    input  logic [DW-1:0]    adc_dat_i,
    input  logic [2:0]       cfg_dec_i,
    input  logic             cfg_avg_en_i,
    input  logic             cfg_restart_i,
    output logic [DW-1:0]    dec_dat_o,
    output logic             dec_vld_o,
    output logic [CNT_W-1:0] dec_cnt_o
);

    // accumulator holds up to 2^16 samples of 14 bits plus a guard bit
    localparam int ACC_W = DW + CNT_W;

    logic [2:0]              r_code;
    logic                    r_avg_en;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [ACC_W-1:0] r_acc;
    logic [DW-1:0]           r_dat;
    logic                    r_vld;

    logic                    w_restart;
    logic [4:0]              w_shift;
    logic [CNT_W-1:0]        w_last;
    logic signed [ACC_W-1:0] w_sum;
    logic [DW-1:0]           w_mean;

    // any config change behaves exactly like an explicit restart pulse
    assign w_restart = cfg_restart_i
                     | (cfg_dec_i != r_code)
                     | (cfg_avg_en_i != r_avg_en);

    assign w_shift = dec_shift(r_code);
    assign w_last  = CNT_W'(dec_last(r_code));
    assign w_sum   = r_acc + {{(ACC_W-DW){adc_dat_i[DW-1]}}, adc_dat_i};
    // arithmetic shift floors toward -inf; the mean always fits in DW bits
    assign w_mean  = DW'(w_sum >>> w_shift);

    // latch the configuration whenever a restart condition is seen
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            r_code   <= DEC_CODE_1;
            r_avg_en <= 1'b0;
        end else if (w_restart) begin
            r_code   <= cfg_dec_i;
            r_avg_en <= cfg_avg_en_i;
        end
    end

    // window counter, accumulator and output register
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (w_restart) begin
            // the sample presented in this cycle is dropped; output data holds
            r_cnt <= '0;
            r_acc <= '0;
            r_vld <= 1'b0;
        end else if (r_cnt == w_last) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_vld <= 1'b1;
            r_dat <= r_avg_en ? w_mean : adc_dat_i;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_acc <= w_sum;
            r_vld <= 1'b0;
        end
    end

    assign dec_dat_o = r_dat;
    assign dec_vld_o = r_vld;
    assign dec_cnt_o = r_cnt;

endmodule
